// File: rtl/cpu_test_controller.sv
// Run controller for the CPU test harness: sequences core reset,
// counts RUN cycles/retires, and reports PASS/FAIL/TIMEOUT via tohost.
//
// Ports:
//   clk, reset        clock and async active-high reset
//   mem_we/addr/wdata CPU store bus, watched for tohost writes
//   instr_retire      one pulse per retired instruction
//   cpu_reset         registered reset to the core
//   done/pass/timeout run result flags
//   fail_code         wdata[XLEN-1:1] of the failing tohost store
//   cycle_count       RUN cycles (saturating)
//   instret_count     RUN retires (saturating)
module cpu_test_controller #(
  parameter int              XLEN         = 32,
  parameter int              CNT_W        = 32,
  parameter int              RESET_CYCLES = 2,
  parameter int              MAX_CYCLES   = 1500,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_we,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic              instr_retire,
  output logic              cpu_reset,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [XLEN-2:0]   fail_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret_count
);

  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  typedef enum logic [2:0] {
    S_HOLD,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              crst_d, done_d, pass_d, to_d;
  logic [XLEN-2:0]   fc_d;
  logic [CNT_W-1:0]  cyc_d, ins_d;
  logic              tohost;

  assign tohost = mem_we && (mem_addr == TOHOST_ADDR);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    crst_d  = cpu_reset;
    done_d  = done;
    pass_d  = pass;
    to_d    = timeout;
    fc_d    = fail_code;
    cyc_d   = cycle_count;
    ins_d   = instret_count;
    unique case (state_q)
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
          crst_d  = 1'b0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_RUN: begin
        if (cycle_count != CNT_SAT)
          cyc_d = cycle_count + CNT_W'(1);
        if (instr_retire && instret_count != CNT_SAT)
          ins_d = instret_count + CNT_W'(1);
        // Even-valued tohost stores are not results; keep running.
        if (tohost && mem_wdata[0]) begin
          done_d = 1'b1;
          crst_d = 1'b1;
          if (mem_wdata == XLEN'(1)) begin
            state_d = S_PASS;
            pass_d  = 1'b1;
          end else begin
            state_d = S_FAIL;
            fc_d    = mem_wdata[XLEN-1:1];
          end
        end else if (cycle_count == CYC_LAST) begin
          state_d = S_TIMEOUT;
          done_d  = 1'b1;
          to_d    = 1'b1;
          crst_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_HOLD;
      hold_q        <= '0;
      cpu_reset     <= 1'b1;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      fail_code     <= '0;
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      cpu_reset     <= crst_d;
      done          <= done_d;
      pass          <= pass_d;
      timeout       <= to_d;
      fail_code     <= fc_d;
      cycle_count   <= cyc_d;
      instret_count <= ins_d;
    end
  end

endmodule

// File: tb/tb_cpu_test_controller.sv
// Directed bench for cpu_test_controller: reset sequencing, pass/fail,
// timeout, async reset and a parameter sweep on extra instances.
module tb_cpu_test_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        instr_retire = 1'b0;
  logic        cpu_reset, done, pass, timeout;
  logic [30:0] fail_code;
  logic [31:0] cycle_count, instret_count;

  logic        sw_we = 1'b0;
  logic [31:0] sw_addr = '0;
  logic [31:0] sw_wdata = '0;
  logic        sw_ret = 1'b1;

  logic        a_crst, a_done, a_pass, a_to;
  logic [30:0] a_fc;
  logic [31:0] a_cyc, a_ins;
  logic        b_crst, b_done, b_pass, b_to;
  logic [30:0] b_fc;
  logic [3:0]  b_cyc, b_ins;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_test_controller dut (
    .clk(clk), .reset(reset),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .instr_retire(instr_retire),
    .cpu_reset(cpu_reset), .done(done), .pass(pass), .timeout(timeout),
    .fail_code(fail_code), .cycle_count(cycle_count),
    .instret_count(instret_count)
  );

  cpu_test_controller #(.RESET_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset),
    .mem_we(sw_we), .mem_addr(sw_addr), .mem_wdata(sw_wdata),
    .instr_retire(sw_ret),
    .cpu_reset(a_crst), .done(a_done), .pass(a_pass), .timeout(a_to),
    .fail_code(a_fc), .cycle_count(a_cyc), .instret_count(a_ins)
  );

  cpu_test_controller #(
    .RESET_CYCLES(5), .CNT_W(4), .MAX_CYCLES(15)
  ) dut_b (
    .clk(clk), .reset(reset),
    .mem_we(sw_we), .mem_addr(sw_addr), .mem_wdata(sw_wdata),
    .instr_retire(sw_ret),
    .cpu_reset(b_crst), .done(b_done), .pass(b_pass), .timeout(b_to),
    .fail_code(b_fc), .cycle_count(b_cyc), .instret_count(b_ins)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_we = 1'b1; mem_addr = a; mem_wdata = d;
    tick();
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".crst"}, cpu_reset, 1);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass, 0);
    chk({tag, ".to"}, timeout, 0);
    chk({tag, ".fc"}, fail_code, 0);
    chk({tag, ".cyc"}, cycle_count, 0);
    chk({tag, ".ins"}, instret_count, 0);
  endtask

  // Reset pulse then release; leaves the main DUT in RUN, count 0.
  task automatic restart();
    @(posedge clk); #1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
    chk("hold.edge0", cpu_reset, 1);
    tick();
    chk("hold.edge1", cpu_reset, 0);
    chk("run.cyc0", cycle_count, 0);
  endtask

  initial begin
    // Power-on reset, plus the RESET_CYCLES / CNT_W sweep.
    tick(2);
    chk_rst("por");
    chk("a.por.crst", a_crst, 1);
    chk("b.por.crst", b_crst, 1);
    reset = 1'b0;
    tick();
    chk("e0.crst", cpu_reset, 1);
    chk("a.e0.crst", a_crst, 0);
    chk("b.e0.crst", b_crst, 1);
    tick();
    chk("e1.crst", cpu_reset, 0);
    chk("e1.cyc", cycle_count, 0);
    chk("b.e1.crst", b_crst, 1);
    tick(2);
    chk("b.e3.crst", b_crst, 1);
    chk("e3.cyc", cycle_count, 2);
    tick();
    chk("b.e4.crst", b_crst, 0);
    chk("b.e4.ins", b_ins, 0);
    tick(15);
    chk("b.to", b_to, 1);
    chk("b.cyc", b_cyc, 15);
    chk("b.ins", b_ins, 15);
    tick(5);
    chk("b.ins.sat", b_ins, 15);
    chk("b.crst.frz", b_crst, 1);

    // PASS with 7 retires over 10 RUN cycles.
    restart();
    for (int i = 0; i < 10; i++) begin
      instr_retire = (i < 7);
      tick();
    end
    instr_retire = 1'b0;
    chk("p.cyc10", cycle_count, 10);
    chk("p.ins7", instret_count, 7);
    chk("p.pre.done", done, 0);
    store(32'h1000, 32'h1);
    chk("p.done", done, 1);
    chk("p.pass", pass, 1);
    chk("p.to", timeout, 0);
    chk("p.cyc", cycle_count, 11);
    chk("p.ins", instret_count, 7);
    chk("p.crst", cpu_reset, 1);
    instr_retire = 1'b1;
    mem_we = 1'b1; mem_addr = 32'h1000; mem_wdata = 32'h3;
    tick(20);
    mem_we = 1'b0; instr_retire = 1'b0;
    chk("p.frz.cyc", cycle_count, 11);
    chk("p.frz.ins", instret_count, 7);
    chk("p.frz.pass", pass, 1);
    chk("p.frz.fc", fail_code, 0);

    // Async reset while in PASS, between edges.
    #2;
    reset = 1'b1;
    #1;
    chk_rst("rst.pass");
    reset = 1'b0;
    tick();
    chk("rp.e0.crst", cpu_reset, 1);
    tick();
    chk("rp.e1.crst", cpu_reset, 0);

    // FAIL, with ignored stores first.
    tick(3);
    store(32'h1000, 32'h4);
    chk("f.even.done", done, 0);
    store(32'h1004, 32'h1);
    chk("f.addr.done", done, 0);
    chk("f.pre.cyc", cycle_count, 5);
    store(32'h1000, 32'h7);
    chk("f.done", done, 1);
    chk("f.pass", pass, 0);
    chk("f.to", timeout, 0);
    chk("f.fc", fail_code, 3);
    chk("f.cyc", cycle_count, 6);
    chk("f.crst", cpu_reset, 1);

    // Async reset mid-run at cycle_count 50.
    restart();
    tick(50);
    chk("m.cyc50", cycle_count, 50);
    #2;
    reset = 1'b1;
    #1;
    chk_rst("rst.run");
    reset = 1'b0;
    tick();
    chk("rm.e0.crst", cpu_reset, 1);
    tick();
    chk("rm.e1.crst", cpu_reset, 0);
    tick();
    chk("rm.cyc1", cycle_count, 1);

    // Timeout after exactly 1500 RUN edges.
    restart();
    tick(1499);
    chk("t.cyc1499", cycle_count, 1499);
    chk("t.pre.done", done, 0);
    tick();
    chk("t.done", done, 1);
    chk("t.to", timeout, 1);
    chk("t.pass", pass, 0);
    chk("t.cyc", cycle_count, 1500);
    tick(3);
    chk("t.frz.cyc", cycle_count, 1500);

    // Tohost store on the timeout edge wins.
    restart();
    tick(1499);
    store(32'h1000, 32'h1);
    chk("tp.pass", pass, 1);
    chk("tp.to", timeout, 0);
    chk("tp.done", done, 1);
    chk("tp.cyc", cycle_count, 1500);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_test_controller.md
# cpu_test_controller

Synthesizable test-harness controller that sits between the bench clock/reset and the `CPU` core. It sequences the core's reset and counts cycles and retired instructions. It detects pass/fail from a store to a tohost address and ends a hung run with a timeout. It replaces fixed delay-based reset and fixed-length runs with a parametrised, self-reporting run controller usable in simulation and on FPGA.

## Interface
Parameters:
- `XLEN`, 32, data/address width of the monitored store bus
- `CNT_W`, 32, width of cycle and instret counters
- `RESET_CYCLES`, 2, cycles `cpu_reset` stays high after `reset` deasserts; legal range >= 1
- `MAX_CYCLES`, 1500, RUN-state cycle budget before timeout; legal range >= 1 and < 2^CNT_W
- `TOHOST_ADDR`, 32'h0000_1000, store address monitored for test result

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `mem_we`  in  1  CPU data-store strobe, one cycle per store
- `mem_addr`  in  XLEN  CPU data-store address
- `mem_wdata`  in  XLEN  CPU data-store data
- `instr_retire`  in  1  one-cycle pulse per retired instruction
- `cpu_reset`  out  1  reset driven to the CPU core
- `done`  out  1  run finished (PASS, FAIL or TIMEOUT)
- `pass`  out  1  test passed
- `timeout`  out  1  cycle budget exhausted
- `fail_code`  out  XLEN-1  `mem_wdata[XLEN-1:1]` of the failing tohost store
- `cycle_count`  out  CNT_W  cycles spent in RUN
- `instret_count`  out  CNT_W  retire pulses counted in RUN

## Operation
- States: HOLD, RUN, PASS, FAIL, TIMEOUT. All outputs are registered.
- `reset` high, asynchronously:
  - state = HOLD, hold counter = 0
  - `cpu_reset` = 1; `done`, `pass` and `timeout` = 0
  - `fail_code`, `cycle_count` and `instret_count` = 0
- HOLD:
  - Hold counter increments each edge.
  - When it reaches RESET_CYCLES-1, the next state is RUN and `cpu_reset` falls on that same edge.
  - Store-bus and retire inputs are ignored.
- RUN:
  - `cycle_count` increments every cycle.
  - `instret_count` increments on each cycle where `instr_retire` = 1.
  - A tohost store is `mem_we`=1 with `mem_addr`==TOHOST_ADDR, compared over the full XLEN.
  - Tohost store, `mem_wdata`==1: next state PASS.
  - Tohost store, `mem_wdata[0]`==1 and `mem_wdata`!=1: next state FAIL; `fail_code` latches `mem_wdata[XLEN-1:1]`.
  - Tohost store, `mem_wdata[0]`==0: ignored; the run continues.
  - Timeout: if `cycle_count`==MAX_CYCLES-1 on an edge with no qualifying tohost store, the next state is TIMEOUT.
- Terminal states (PASS, FAIL, TIMEOUT):
  - `done` = 1; `pass` = 1 only in PASS; `timeout` = 1 only in TIMEOUT.
  - `cpu_reset` re-asserts to freeze the core.
  - Counters and `fail_code` freeze.
  - All inputs are ignored; the block leaves only via `reset`.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset release: with `reset` falling before edge 0, `cpu_reset` is low after edge RESET_CYCLES-1. Default: low after the 2nd edge.
- Tohost store sampled on edge N: `done`/`pass` (or `fail_code`) are visible after edge N. Latency is 1 cycle and that cycle's `cycle_count` increment is included.
- Timeout: `done`=`timeout`=1 after the MAX_CYCLES-th RUN edge; `cycle_count` reads MAX_CYCLES.
- Tohost store on the timeout edge: the tohost store wins, giving PASS or FAIL, not TIMEOUT.
- A retire pulse on the terminating edge is counted.
- `reset` mid-run in any state: immediate asynchronous return to HOLD with all outputs at reset values; the reset sequence restarts.
- `cpu_reset` is a register output, glitch-free; it is high throughout `reset` assertion.

## Test plan
- Defaults, `reset` high for 2 cycles then low: `cpu_reset`=1 until the 2nd edge after release, then 0; `cycle_count` starts at 0 and increments by 1 per cycle.
- RUN for 10 cycles, 7 `instr_retire` pulses, then store 1 to 0x1000: next cycle `done`=1, `pass`=1, `cycle_count`=11, `instret_count`=7, `cpu_reset`=1; values stay frozen for 20 further cycles.
- Store 0x0000_0007 to 0x1000: `done`=1, `pass`=0, `fail_code`=3. Earlier stores of 0x0000_0004 to 0x1000 and 0x1 to 0x1004 cause no state change.
- No tohost store, MAX_CYCLES=1500: `timeout`=`done`=1 and `cycle_count`=1500 exactly after the 1500th RUN edge. Variant with store 1 to 0x1000 on that same edge: `pass`=1, `timeout`=0.
- Assert `reset` asynchronously mid-run (between edges, at `cycle_count`=50) and mid-PASS: outputs return to reset values immediately without a clock edge; after release the full HOLD→RUN sequence repeats.
- Parameter sweep RESET_CYCLES=1 and 5, CNT_W=4 with MAX_CYCLES=15: `cpu_reset` falls after the 1st and 5th edge respectively; `instret_count` with continuous retire saturates at 15 without wrapping.
